// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and divide unit with architectural HI/LO registers.
// Latency: result in HI/LO and done pulse WIDTH+1 edges after the accepting edge.
// Backpressure: busy high while working; start and HI/LO writes are dropped (not queued) while busy.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched operation context
    logic                 is_div;     // op[1]: divide when set
    logic                 res_neg;    // product / quotient needs negation
    logic                 rem_neg;    // remainder needs negation
    logic                 div_zero;   // divisor was zero at acceptance
    logic [WIDTH-1:0]     a_raw;      // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]     opd;        // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0]   acc;        // {upper, lower} working accumulator
    logic [CW-1:0]        cnt;

    // Control strobes
    logic accept;
    logic fix_en;
    logic mt_en;

    // Operand conditioning at acceptance
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Per-iteration next values
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_nxt;
    logic [WIDTH:0]       div_cand;
    logic [WIDTH:0]       div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   div_nxt;

    // Sign-corrected results
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: WIDTH iterations in CALC, one FIX cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and strobes
    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && start;
        mt_en  = (state == IDLE);
        fix_en = (state == FIX);
    end

    // Operand magnitudes and signs; op[0] clear means signed
    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & operand_a[WIDTH-1];
        b_neg     = is_signed & operand_b[WIDTH-1];
        a_mag     = a_neg ? (~operand_a + 1'b1) : operand_a;
        b_mag     = b_neg ? (~operand_b + 1'b1) : operand_b;
    end

    // One shift-add step and one restoring-division step
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : {WIDTH{1'b0}})};
        mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
        div_cand = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_cand - {1'b0, opd};
        div_ok   = ~div_diff[WIDTH];
        div_nxt  = {(div_ok ? div_diff[WIDTH-1:0] : div_cand[WIDTH-1:0]), acc[WIDTH-2:0], div_ok};
    end

    // Sign correction and divide-by-zero override applied in FIX
    always_comb begin
        prod_fix = res_neg ? (~acc + 1'b1) : acc;
        quo_fix  = res_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = rem_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            res_hi = a_raw;
            res_lo = {WIDTH{1'b1}};
        end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
    end

    // Operation context, accumulator and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div   <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            opd      <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else if (accept) begin
            is_div   <= op[1];
            res_neg  <= a_neg ^ b_neg;
            rem_neg  <= a_neg;
            div_zero <= op[1] && (operand_b == '0);
            a_raw    <= operand_a;
            opd      <= op[1] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            cnt      <= '0;
        end else if (state == CALC) begin
            acc <= is_div ? div_nxt : mul_nxt;
            cnt <= cnt + 1'b1;
        end
    end

    // HI/LO: MTHI/MTLO only in IDLE, operation result in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (fix_en) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (mt_en) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

    // Registered completion pulse, coincident with the HI/LO update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= fix_en;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: reference results and due cycles queued at issue.
// Latency: checks done lands exactly 33 edges after the accepting edge.
// Backpressure: exercises start/MTHI while busy, held start, and mid-operation reset.
module tb_mult_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
    // the remainder keeps the dividend's sign.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      na, nb, q, r;
        e.due = 0;
        case (o)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd1: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    e.hi = a;
                    e.lo = '1;
                end else begin
                    if (o == 2'd2) begin
                        na = longint'($signed(a));
                        nb = longint'($signed(b));
                    end else begin
                        na = longint'({32'b0, a});
                        nb = longint'({32'b0, b});
                    end
                    q = na / nb;
                    r = na % nb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: pops and compares on every done pulse, also checks timing
    int busy_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                check("busy_low_at_done", {63'b0, busy}, 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("hi", {32'b0, hi}, {32'b0, e.hi});
                    check("lo", {32'b0, lo}, {32'b0, e.lo});
                    check("done_latency", 64'(cyc), 64'(e.due));
                    check("busy_cycles", 64'(busy_run), 64'(LAT));
                end
                busy_run = 0;
            end
        end
    end

    // Caller is always at #1 after a rising edge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got busy=1 expected 0 within 200 cycles");
        end
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk); #1;
        e     = model(o, a, b);
        e.due = cyc + LAT;
        sb.push_back(e);
        start     = 1'b0;
        op        = 2'($urandom_range(0, 3));
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        exp_t         e2;
        int           t1;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi",   {32'b0, hi}, 64'd0);
        check("rst_lo",   {32'b0, lo}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        issue(2'd0, 32'hFFFF_FFFD, 32'd5);           drain();
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   drain();
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);           drain();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);   drain();
        issue(2'd3, 32'd7, 32'd0);                   drain();
        issue(2'd2, 32'hFFFF_FFF9, 32'd0);           drain();
        issue(2'd2, 32'd7, 32'hFFFF_FFFE);           drain();

        // start + MTHI while busy are both ignored
        issue(2'd1, 32'd6, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; op = 2'd3; operand_a = 32'd1000; operand_b = 32'd9;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        check("busy_mid_calc", {63'b0, busy}, 64'd1);
        drain();

        // start held through busy is accepted at the done cycle's edge
        issue(2'd0, 32'h1234_5678, 32'h8765_4321);
        t1 = cyc;
        start = 1'b1; op = 2'd3; operand_a = 32'd1000; operand_b = 32'd7;
        e2 = model(2'd3, 32'd1000, 32'd7);
        e2.due = t1 + LAT + 1 + LAT;
        sb.push_back(e2);
        repeat (LAT + 1) @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Randomized, issued back to back
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            issue(ro, ra, rb);
        end
        drain();

        // Mid-operation reset discards the operation
        issue(2'd3, 32'd100, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_hi",   {32'b0, hi}, 64'd0);
        check("midrst_lo",   {32'b0, lo}, 64'd0);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_done", {63'b0, done}, 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MTLO / MTHI in IDLE
        lo_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("mtlo_lo", {32'b0, lo}, 64'h1234);
        check("mtlo_hi", {32'b0, hi}, 64'd0);
        hi_we = 1'b1; wdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        hi_we = 1'b0;
        check("mthi_hi", {32'b0, hi}, 64'hCAFE_0001);
        check("mthi_lo", {32'b0, lo}, 64'h1234);

        // Operation after reset recovers; start with MTHI lets the result win
        hi_we = 1'b1; wdata = 32'h5555_5555;
        issue(2'd3, 32'd100, 32'd3);
        hi_we = 1'b0;
        check("mthi_with_start", {32'b0, hi}, 64'h5555_5555);
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
